video_timing_ctrl: RTL

VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

---
 rtl/video_timing_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl
// Purpose  : Raster timing generator (hs/vs/blank, position, sof/eol, frames)
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_ctrl #(
    parameter int H_DISP = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_DISP = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        restart,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        sof,
    output logic        eol,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_H_ACT    = 11'(H_DISP);
    localparam logic [10:0] C_HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] C_HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_V_ACT    = 10'(V_DISP);
    localparam logic [9:0]  C_VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0]  C_VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [7:0]  frame_q, frame_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        w_step;

    // Decoded outputs are computed from the next position so the flops
    // present outputs that match the position they hold.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        frame_d = frame_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        w_step  = 1'b0;

        if (restart) begin
            state_d = IDLE;
            hcnt_d  = '0;
            vcnt_d  = '0;
            frame_d = '0;
            hs_d    = ~HS_POL;
            vs_d    = ~VS_POL;
            blank_d = 1'b1;
        end else if (en) begin
            w_step = 1'b1;
            if (state_q == IDLE) begin
                state_d = RUN;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end else if (hcnt_q == C_H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == C_V_LAST) begin
                    vcnt_d  = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 11'd1;
            end
        end

        if (w_step) begin
            hs_d    = (hcnt_d >= C_HS_START && hcnt_d < C_HS_END) ? HS_POL : ~HS_POL;
            vs_d    = (vcnt_d >= C_VS_START && vcnt_d < C_VS_END) ? VS_POL : ~VS_POL;
            blank_d = ~(hcnt_d < C_H_ACT && vcnt_d < C_V_ACT);
            sof_d   = (hcnt_d == 11'd0) && (vcnt_d == 10'd0);
            eol_d   = (hcnt_d == C_H_LAST);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b1;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign hs        = hs_q;
    assign vs        = vs_q;
    assign blank     = blank_q;
    assign pix_x     = hcnt_q;
    assign pix_y     = vcnt_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign frame_cnt = frame_q;

endmodule
`default_nettype wire
